// File: rtl/nor_pkg.sv
// nor_pkg: shared constants and next-state helper for the NOR set/reset bank.
// Contents:
//   POL_HOLD/POL_SET/POL_RST - encodings for the S=R=1 resolution policy
//   MAX_WIDTH                - largest supported channel count
//   sr_next()                - next state of one set/reset channel
package nor_pkg;

    localparam int POL_HOLD  = 0;
    localparam int POL_SET   = 1;
    localparam int POL_RST   = 2;
    localparam int MAX_WIDTH = 32;

    function automatic logic sr_next(input logic s, input logic r, input logic q, input int policy);
        logic both;
        both = (policy == POL_SET) ? 1'b1 : (policy == POL_RST) ? 1'b0 : q;
        return (s & r) ? both : s ? 1'b1 : r ? 1'b0 : q;
    endfunction

endpackage

// File: rtl/nor_sr_cell.sv
// nor_sr_cell: one clocked set/reset channel with configurable S=R=1 resolution.
// Ports:
//   CLK - clock, state updates on rising edge
//   RST - asynchronous active-high reset, forces Q=0
//   S   - set request
//   R   - reset request
//   Q   - registered channel state
//   QN  - inverse of Q
// Parameter POLICY selects S=R=1 behaviour (see nor_pkg).
module nor_sr_cell
    import nor_pkg::*;
#(
    parameter int POLICY = POL_HOLD
) (
    input  logic CLK,
    input  logic RST,
    input  logic S,
    input  logic R,
    output logic Q,
    output logic QN
);

    logic q_q, q_d;

    always_comb begin
        q_d = sr_next(S, R, q_q, POLICY);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) q_q <= 1'b0;
        else     q_q <= q_d;
    end

    assign Q  = q_q;
    assign QN = ~q_q;

endmodule

// File: rtl/nor_sr_bank.sv
// nor_sr_bank: bank of WIDTH independent clocked set/reset channels with
// all-clear NOR flag, registered illegal-input flag and saturating error counter.
// Ports:
//   CLK     - clock, all state updates on rising edge
//   RST     - asynchronous active-high reset
//   S, R    - per-channel set / reset requests [WIDTH]
//   CLR_CNT - synchronous clear of ERRCNT (wins over increment)
//   Q, QN   - channel state and its inverse [WIDTH]
//   NOR     - 1 when every channel is clear
//   ILLEGAL - 1 for the cycle after S&R was nonzero on any channel
//   ERRCNT  - saturating count of illegal cycles [CNTW]
// Optional macro NOR_SR_BANK_SYNC_EN inserts a 2-flop synchroniser on S and R.
module nor_sr_bank
    import nor_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int POLICY = POL_HOLD,
    parameter int CNTW   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             CLR_CNT,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             NOR,
    output logic             ILLEGAL,
    output logic [CNTW-1:0]  ERRCNT
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("nor_sr_bank: WIDTH out of range");
    end

    logic [WIDTH-1:0] s_c, r_c;

`ifdef NOR_SR_BANK_SYNC_EN
    logic [WIDTH-1:0] s1_q, s2_q, r1_q, r2_q;
    logic [WIDTH-1:0] s1_d, s2_d, r1_d, r2_d;

    always_comb begin
        s1_d = S;
        s2_d = s1_q;
        r1_d = R;
        r2_d = r1_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= '0;
            s2_q <= '0;
            r1_q <= '0;
            r2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
        end
    end

    assign s_c = s2_q;
    assign r_c = r2_q;
`else
    assign s_c = S;
    assign r_c = R;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        nor_sr_cell #(.POLICY(POLICY)) u_cell (
            .CLK (CLK),
            .RST (RST),
            .S   (s_c[i]),
            .R   (r_c[i]),
            .Q   (Q[i]),
            .QN  (QN[i])
        );
    end

    // Reduction of registered Q only, so NOR changes solely at clock edges.
    assign NOR = ~|Q;

    logic            ill_q, ill_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        ill_d = |(s_c & r_c);
        cnt_d = CLR_CNT ? '0 : (ill_d && cnt_q != {CNTW{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ill_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ill_q <= ill_d;
            cnt_q <= cnt_d;
        end
    end

    assign ILLEGAL = ill_q;
    assign ERRCNT  = cnt_q;

endmodule

// File: doc/nor_sr_bank.md
NOR_SR_BANK -- requirements
Module: nor_sr_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the number of independent set/reset channels (1..32).
REQ-002 The block SHALL have parameter POLICY, default 0, the S=R=1 resolution: 0 hold, 1 set-wins, 2 reset-wins.
REQ-003 The block SHALL have parameter CNTW, default 8, the width of the illegal-input counter.
REQ-004 The block SHALL have port CLK, input, 1 bit, the sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit; reset is asynchronous and active-high.
REQ-006 The block SHALL have port S, input, WIDTH bits, per-channel set request.
REQ-007 The block SHALL have port R, input, WIDTH bits, per-channel reset request.
REQ-008 The block SHALL have port CLR_CNT, input, 1 bit, synchronous clear of ERRCNT.
REQ-009 The block SHALL have port Q, output, WIDTH bits, channel state.
REQ-010 The block SHALL have port QN, output, WIDTH bits, always the bitwise inverse of Q.
REQ-011 The block SHALL have port NOR, output, 1 bit, NOR-reduction of Q (1 when all channels clear).
REQ-012 The block SHALL have port ILLEGAL, output, 1 bit, registered flag: the previous sampled S/R had S&R nonzero on any channel.
REQ-013 The block SHALL have port ERRCNT, output, CNTW bits, saturating count of illegal cycles.

Function
REQ-014 Per channel, each edge SHALL apply: S=0,R=0 hold; S=1,R=0 Q<=1; S=0,R=1 Q<=0; S=1,R=1 per POLICY.
REQ-015 Input-to-Q latency SHALL be exactly 1 CLK edge; Q, QN, NOR and ILLEGAL SHALL all update on the same edge.
REQ-016 NOR SHALL be derived from registered Q and never glitch between edges.
REQ-017 ILLEGAL SHALL assert for exactly one cycle per cycle in which any channel sampled S=R=1, regardless of POLICY.
REQ-018 ERRCNT SHALL increment by 1 on each edge where S&R is nonzero, saturating at 2^CNTW-1 with no wrap.
REQ-019 If CLR_CNT is asserted simultaneously with an illegal cycle, ERRCNT SHALL load 0 (clear wins).
REQ-020 Channels SHALL be fully independent; an illegal pattern on one channel SHALL not affect any other channel.

Reset
REQ-021 While RST=1, the block SHALL force Q=0, QN=all ones, NOR=1, ILLEGAL=0, ERRCNT=0 immediately, without a clock.
REQ-022 When RST is asserted mid-operation, the block SHALL discard pending inputs; the first update after release SHALL occur on the first CLK edge with RST=0.

Configuration
REQ-023 When macro NOR_SR_BANK_SYNC_EN is defined, S and R SHALL pass through a 2-flop synchroniser (reset to 0) before the cell logic, making input-to-Q latency 3 edges and ILLEGAL/ERRCNT aligned to the synchronised samples.
REQ-024 When NOR_SR_BANK_SYNC_EN is undefined, no synchroniser SHALL exist and latency SHALL be 1 edge per REQ-015.

Structure
REQ-025 Package nor_pkg SHALL hold the POLICY encodings (POL_HOLD=0, POL_SET=1, POL_RST=2) and the maximum WIDTH constant.
REQ-026 Each channel SHALL be one instance of sub-module nor_sr_cell (S, R, CLK, RST, Q, QN, parameter POLICY), generated WIDTH times; reduction, ILLEGAL and counter logic SHALL stay in nor_sr_bank.

Verification
REQ-027 The bench SHALL cover reset: RST=1 with no CLK -> Q=0, QN=all ones, NOR=1, ERRCNT=0.
REQ-028 The bench SHALL cover set/reset (WIDTH=4, POLICY=0): S=0101 one cycle -> Q=0101, NOR=0; then R=0100 -> Q=0001; then R=0001 -> Q=0000, NOR=1.
REQ-029 The bench SHALL cover illegal policy: from Q=0000, S=R=0010 for POLICY 0/1/2 -> Q=0000/0010/0000, with ILLEGAL=1 for one cycle in each case.
REQ-030 The bench SHALL cover saturation (CNTW=3): 10 consecutive illegal cycles -> ERRCNT=7 and stays 7; CLR_CNT together with an illegal cycle -> ERRCNT=0.
REQ-031 The bench SHALL cover reset mid-operation: with Q=1111, assert RST between edges -> Q=0000 before the next edge; after release, S=1000 -> Q=1000 on the first edge.
REQ-032 The bench SHALL cover NOR_SR_BANK_SYNC_EN defined: S=0001 pulsed one cycle -> Q=0001 on the third edge, not earlier.
